// File: rtl/simmem_pkg.sv
// Shared types and defaults for the simulated-memory release scheduler.
package simmem_pkg;

    localparam int DefaultDelayWidth = 8;

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_COUNTING,
        SLOT_ELIGIBLE
    } slot_state_e;

endpackage

// File: rtl/simmem_delay_slot.sv
// One bank slot: waits for an arm, counts down memory-clock ticks,
// then stays eligible until the bank reports the message has left.
module simmem_delay_slot
    import simmem_pkg::*;
#(
    parameter int DelayWidth = DefaultDelayWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  arm_i,
    input  logic [DelayWidth-1:0] delay_i,
    input  logic                  tick_i,
    input  logic                  release_i,
    output logic                  eligible_o,
    output logic                  busy_o,
    output logic                  bad_release_o
);

    slot_state_e           state;
    slot_state_e           state_next;
    logic [DelayWidth-1:0] cnt;
    logic [DelayWidth-1:0] cnt_next;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= SLOT_FREE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The acceptance cycle itself consumes a tick when tick_i is high.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            SLOT_FREE: begin
                if (arm_i) begin
                    if ((delay_i <= DelayWidth'(1) && tick_i) || delay_i == '0) begin
                        state_next = SLOT_ELIGIBLE;
                        cnt_next   = '0;
                    end else begin
                        state_next = SLOT_COUNTING;
                        cnt_next   = delay_i - DelayWidth'(tick_i);
                    end
                end
            end
            SLOT_COUNTING: begin
                if (tick_i) begin
                    if (cnt == DelayWidth'(1)) begin
                        state_next = SLOT_ELIGIBLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt - DelayWidth'(1);
                    end
                end
            end
            SLOT_ELIGIBLE: begin
                if (release_i) begin
                    state_next = SLOT_FREE;
                end
            end
            default: begin
                state_next = SLOT_FREE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        eligible_o    = (state == SLOT_ELIGIBLE);
        busy_o        = (state != SLOT_FREE);
        bad_release_o = release_i && (state != SLOT_ELIGIBLE);
    end

endmodule

// File: rtl/simmem_release_scheduler.sv
// Per-bank release scheduler: one delay slot per bank address, plus the
// arm/release address decode, the pending-slot count and a sticky error.
module simmem_release_scheduler
    import simmem_pkg::*;
#(
    parameter int TotalCapacity = 32,
    parameter int DelayWidth    = DefaultDelayWidth,
    localparam int AddrWidth    = $clog2(TotalCapacity)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     tick_i,
    input  logic                     arm_valid_i,
    output logic                     arm_ready_o,
    input  logic [AddrWidth-1:0]     arm_addr_i,
    input  logic [DelayWidth-1:0]    arm_delay_i,
    input  logic                     released_valid_i,
    input  logic [AddrWidth-1:0]     released_addr_i,
    output logic [TotalCapacity-1:0] release_en_o,
    output logic [AddrWidth:0]       pending_cnt_o,
    output logic                     error_o
);

    logic [TotalCapacity-1:0] busy;
    logic [TotalCapacity-1:0] arm_hit;
    logic [TotalCapacity-1:0] release_hit;
    logic [TotalCapacity-1:0] bad_release;
    logic                     arm_fire;
    logic                     release_ok;
    logic [AddrWidth:0]       pending_next;

    // Addresses beyond the slot range never report ready.
    always_comb begin
        arm_ready_o = 1'b0;
        for (int i = 0; i < TotalCapacity; i++) begin
            if (arm_addr_i == AddrWidth'(i)) begin
                arm_ready_o = !busy[i];
            end
        end
    end

    assign arm_fire = arm_valid_i && arm_ready_o;

    for (genvar g = 0; g < TotalCapacity; g++) begin : g_slot
        assign arm_hit[g]     = arm_fire && (arm_addr_i == AddrWidth'(g));
        assign release_hit[g] = released_valid_i && (released_addr_i == AddrWidth'(g));

        simmem_delay_slot #(
            .DelayWidth(DelayWidth)
        ) u_slot (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .arm_i        (arm_hit[g]),
            .delay_i      (arm_delay_i),
            .tick_i       (tick_i),
            .release_i    (release_hit[g]),
            .eligible_o   (release_en_o[g]),
            .busy_o       (busy[g]),
            .bad_release_o(bad_release[g])
        );
    end

    // At most one arm and one release per cycle, so the count moves by -1..+1.
    assign release_ok   = |(release_hit & release_en_o);
    assign pending_next = pending_cnt_o + (AddrWidth + 1)'(arm_fire)
                                        - (AddrWidth + 1)'(release_ok);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_cnt_o <= '0;
            error_o       <= 1'b0;
        end else begin
            pending_cnt_o <= pending_next;
            error_o       <= error_o | (|bad_release);
        end
    end

endmodule

// File: tb/tb_simmem_release_scheduler.sv
// Randomized and directed bench for simmem_release_scheduler against a
// tick-counting reference model of each slot.
module tb_simmem_release_scheduler;

    localparam int N  = 32;
    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick;
    logic          arm_valid;
    logic          arm_ready;
    logic [AW-1:0] arm_addr;
    logic [DW-1:0] arm_delay;
    logic          rel_valid;
    logic [AW-1:0] rel_addr;
    logic [N-1:0]  release_en;
    logic [AW:0]   pending_cnt;
    logic          error;

    int total = 0;
    int bad   = 0;

    // Model: a busy slot needs m_rem more ticks; it is eligible at zero.
    bit m_busy[N];
    int m_rem[N];
    bit m_err;

    simmem_release_scheduler #(
        .TotalCapacity(N),
        .DelayWidth   (DW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .tick_i          (tick),
        .arm_valid_i     (arm_valid),
        .arm_ready_o     (arm_ready),
        .arm_addr_i      (arm_addr),
        .arm_delay_i     (arm_delay),
        .released_valid_i(rel_valid),
        .released_addr_i (rel_addr),
        .release_en_o    (release_en),
        .pending_cnt_o   (pending_cnt),
        .error_o         (error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model_en();
        logic [N-1:0] en;
        for (int i = 0; i < N; i++) en[i] = m_busy[i] && (m_rem[i] == 0);
        return en;
    endfunction

    function automatic int model_pending();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_rem[i]  = 0;
        end
        m_err = 1'b0;
    endfunction

    // One clock: drive, check ready, advance the model with the edge, check outputs.
    task automatic applyStimulus(input bit r, input bit t, input bit av, input int aa,
                                 input int ad, input bit rv, input int ra);
        bit fire;
        rst_n     = r;
        tick      = t;
        arm_valid = av;
        arm_addr  = AW'(aa);
        arm_delay = DW'(ad);
        rel_valid = rv;
        rel_addr  = AW'(ra);
        #1;
        checkOutput("arm_ready", 64'(arm_ready), 64'(!m_busy[aa]));
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else begin
            fire = av && !m_busy[aa];
            if (rv) begin
                if (m_busy[ra] && m_rem[ra] == 0) m_busy[ra] = 1'b0;
                else m_err = 1'b1;
            end
            for (int i = 0; i < N; i++)
                if (m_busy[i] && t && m_rem[i] > 0) m_rem[i]--;
            if (fire) begin
                m_busy[aa] = 1'b1;
                m_rem[aa]  = (t && ad > 0) ? ad - 1 : ad;
            end
        end
        #1;
        checkOutput("release_en", 64'(release_en), 64'(model_en()));
        checkOutput("pending_cnt", 64'(pending_cnt), 64'(model_pending()));
        checkOutput("error", 64'(error), 64'(m_err));
    endtask

    task automatic idle(input bit t, input int n);
        for (int k = 0; k < n; k++) applyStimulus(1, t, 0, k % N, 0, 0, 0);
    endtask

    initial begin
        int ra;
        int elig[$];
        model_reset();
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        idle(1, N);

        // Arm 5 with D=4, hold, then release it.
        applyStimulus(1, 1, 1, 5, 4, 0, 0);
        idle(1, 9);
        applyStimulus(1, 1, 0, 5, 0, 1, 5);
        idle(1, 2);

        // Arm 3 with D=3 under a toggling tick.
        applyStimulus(1, 1, 1, 3, 3, 0, 0);
        for (int k = 0; k < 6; k++) applyStimulus(1, k[0], 0, 3, 0, 0, 0);
        applyStimulus(1, 1, 0, 3, 0, 1, 3);

        // D=0 and D=1 back to back, then re-arm 2 while eligible.
        applyStimulus(1, 1, 1, 2, 0, 0, 0);
        applyStimulus(1, 1, 1, 7, 1, 0, 0);
        applyStimulus(1, 1, 1, 2, 6, 0, 0);
        applyStimulus(1, 1, 0, 2, 0, 1, 2);
        applyStimulus(1, 1, 0, 7, 0, 1, 7);

        // Fill every slot, then release and re-arm slot 0 together.
        for (int i = 0; i < N; i++) applyStimulus(1, 1, 1, i, 2, 0, 0);
        idle(1, 3);
        applyStimulus(1, 1, 1, 0, 2, 1, 0);
        applyStimulus(1, 1, 1, 0, 2, 0, 0);
        idle(1, 3);
        for (int i = 0; i < N; i++) applyStimulus(1, 1, 0, i, 0, 1, i);

        // Early release of a counting slot, then reset mid-countdown.
        applyStimulus(1, 1, 1, 9, 5, 0, 0);
        applyStimulus(1, 1, 0, 9, 0, 1, 9);
        idle(1, 5);
        applyStimulus(1, 1, 0, 9, 0, 1, 9);
        applyStimulus(1, 1, 1, 11, 6, 0, 0);
        idle(1, 2);
        applyStimulus(0, 1, 0, 11, 0, 0, 0);
        idle(1, 8);

        // Random traffic, mostly legal releases, with rare resets.
        for (int k = 0; k < 3000; k++) begin
            elig = {};
            for (int i = 0; i < N; i++) if (m_busy[i] && m_rem[i] == 0) elig.push_back(i);
            if (elig.size() > 0 && $urandom_range(0, 19) != 0)
                ra = elig[$urandom_range(0, elig.size() - 1)];
            else
                ra = $urandom_range(0, N - 1);
            applyStimulus($urandom_range(0, 299) != 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, N - 1),
                          ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 5),
                          $urandom_range(0, 1) == 1,
                          ra);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
